smpl_iter: RTL
==============

# smpl_iter

Sample iterator for the rasterizer pipeline: takes one bounding-boxed triangle per handshake from the bbox stage and walks every sample point of its box on the subsample grid, one sample per cycle. It drives the sample-test/hash stage and the sample-count scoreboard with `tri_R16S`, `color_R16U`, `sample_R16S` and `validSamp_R16H`. Upstream is back-pressured with `halt_RnnnnL` while a triangle is being walked.

## Interface
- `SIGFIG`, 24: bits in position/color fixed-point values
- `RADIX`, 10: fraction bits
- `VERTS`, 3: vertices per triangle
- `AXIS`, 3: axes per vertex (x,y,z)
- `COLORS`, 3: color channels

Ports:
- `clk`  in  1: clock; single clock domain
- `rst`  in  1: reset, asynchronous, active-high
- `tri_R15S`  in  signed SIGFIG × [VERTS][AXIS]: triangle vertices
- `color_R15U`  in  SIGFIG × [COLORS]: triangle color
- `box_R15S`  in  signed SIGFIG × [1:0][1:0]: `[0]` lower-left, `[1]` upper-right, `[.][0]` x, `[.][1]` y; grid-aligned, ll ≤ ur
- `validTri_R15H`  in  1: input triangle valid
- `subSample_RnnnnU`  in  4: one-hot subsample mode
- `screen_RnnnnS`  in  SIGFIG × [1:0]: screen size; pass-through reference only, not used for clipping
- `halt_RnnnnL`  out  1: active-low stall to upstream; 0 means hold inputs
- `tri_R16S`, `color_R16U`  out: triangle and color of the current sample
- `sample_R16S`  out  signed SIGFIG × [1:0]: current sample x,y
- `validSamp_R16H`  out  1: sample outputs valid this cycle

## Operation
- States:
  - `WAIT_STATE`: idle.
  - `TEST_STATE`: walking a box.
- Step size: `step = 1 << (RADIX - ss_w_lg2)`.
  - `ss_w_lg2` = 3/2/1/0 for `subSample_RnnnnU` bit 0/1/2/3 set.
  - The step is latched at accept and held constant for the whole triangle.
- `last` is true when `sample_R16S == box_ur`, with state `TEST_STATE`.
- `halt_RnnnnL = (state == WAIT_STATE) || last`. This is combinational from registered state.
- Accept condition: `accept = halt_RnnnnL && validTri_R15H`.
- On accept, at the clock edge:
  - Register tri, color, box and step.
  - `sample_R16S <= box_ll`.
  - `validSamp_R16H <= 1`.
  - `state <= TEST_STATE`, unless `box_ll == box_ur`. In that case `state <= WAIT_STATE`: single sample, no stall.
- In `TEST_STATE` with no accept:
  - If `!last`: x advances fastest. When `x == ur_x`, x wraps to `ll_x` and `y += step`; otherwise `x += step`. `validSamp_R16H` stays 1.
  - If `last` (and no new triangle): `validSamp_R16H <= 0`, `state <= WAIT_STATE`.
- In `WAIT_STATE` with no accept: `validSamp_R16H <= 0`. Data outputs hold their values.
- Scan order is raster order, x fastest, both edges inclusive. Sample count per box is `((ur_x-ll_x)/step+1) * ((ur_y-ll_y)/step+1)`.
- Arithmetic: SIGFIG-bit signed adds. The wrap test uses equality, so grid alignment of the box is required. The block performs no clamping.

## Timing
- Latency: triangle accepted at edge k; first sample valid in the cycle following edge k.
- An N-sample box:
  - `validSamp_R16H` is high for N consecutive cycles.
  - `halt_RnnnnL` is low for the first N-1 of those cycles.
  - `halt_RnnnnL` is high during the cycle the last sample is shown.
- Back-to-back triangles: a new triangle presented during the `last` cycle is accepted at that edge, with zero bubble.
- Reset values:
  - state `WAIT_STATE`
  - `validSamp_R16H` 0
  - `sample_R16S`, `tri_R16S`, `color_R16U` all 0
  - `halt_RnnnnL` 1
- Reset mid-walk: outputs go to reset values immediately (asynchronous). The in-flight triangle is dropped. The first edge after deassertion can accept.
- `validTri_R15H` low while `halt_RnnnnL` is low: ignored.

## Test plan
- Single box: RADIX=10, `subSample_RnnnnU`=4'b1000, box (0,0)-(2048,1024).
  - 6 samples: (0,0),(1024,0),(2048,0),(0,1024),(1024,1024),(2048,1024).
  - `halt_RnnnnL` low for 5 cycles, then high.
- Fine grid: `subSample_RnnnnU`=4'b0001, box (0,0)-(1024,0).
  - 9 samples, x=0,128,…,1024, y=0.
- Degenerate box: (3072,5120)-(3072,5120).
  - Exactly 1 valid cycle; `halt_RnnnnL` never low; state stays `WAIT_STATE`.
- Back-to-back: second triangle held valid throughout the first triangle's walk.
  - Second accepted on the first's last-sample edge.
  - `validSamp_R16H` continuous for 6+6 cycles.
  - `tri_R16S` switches on cycle 7.
- Reset mid-walk: assert `rst` after 3 samples of a 6-sample box.
  - Asynchronously: `validSamp_R16H`=0, `halt_RnnnnL`=1.
  - After release, a new triangle is accepted and walked from its ll.
- Mode change mid-walk: toggle `subSample_RnnnnU` from 4'b1000 to 4'b0100 during a walk.
  - The current triangle keeps step 1024.
  - The next triangle uses step 512.

Source files
------------

// File: rtl/smpl_iter.sv
// Sample iterator: walks every subsample grid point of a triangle's bounding
// box in raster order (x fastest), one sample per cycle, stalling upstream
// while a box is in progress.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// WAIT_STATE | idle, or showing the single sample of a degenerate box
// TEST_STATE | walking a box; the last sample releases the stall
module smpl_iter #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R15S,
  input  logic        [COLORS-1:0][SIGFIG-1:0]          color_R15U,
  input  logic signed [1:0][1:0][SIGFIG-1:0]            box_R15S,
  input  logic                                          validTri_R15H,
  input  logic        [3:0]                             subSample_RnnnnU,
  input  logic        [1:0][SIGFIG-1:0]                 screen_RnnnnS,
  output logic                                          halt_RnnnnL,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R16S,
  output logic        [COLORS-1:0][SIGFIG-1:0]          color_R16U,
  output logic signed [1:0][SIGFIG-1:0]                 sample_R16S,
  output logic                                          validSamp_R16H
);

  typedef enum logic {WAIT_STATE = 1'b0, TEST_STATE = 1'b1} state_t;

  state_t                   state;
  logic [1:0][1:0][SIGFIG-1:0] box_r;
  logic [SIGFIG-1:0]        step_r;
  logic [SIGFIG-1:0]        step_in;
  logic [3:0]               ss_w_lg2;
  logic                     last;
  logic                     accept;

  // Screen size is carried for downstream reference only; nothing here clips.
  logic unused_screen;
  assign unused_screen = ^screen_RnnnnS;

  // Grid step from the one-hot subsample mode; finest mode wins if several bits are set.
  always_comb begin
    ss_w_lg2 = 4'd0;
    if (subSample_RnnnnU[0])      ss_w_lg2 = 4'd3;
    else if (subSample_RnnnnU[1]) ss_w_lg2 = 4'd2;
    else if (subSample_RnnnnU[2]) ss_w_lg2 = 4'd1;
    else                          ss_w_lg2 = 4'd0;
    step_in = SIGFIG'(1) << (RADIX - int'(ss_w_lg2));
  end

  // Stall and accept decode from registered state; the last sample frees upstream.
  always_comb begin
    last        = (state == TEST_STATE) && (sample_R16S == box_r[1]);
    halt_RnnnnL = (state == WAIT_STATE) || last;
    accept      = halt_RnnnnL && validTri_R15H;
  end

  // Walker FSM: load on accept, raster-step the box, drop valid once the box is done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= WAIT_STATE;
      validSamp_R16H <= 1'b0;
      sample_R16S    <= '0;
      tri_R16S       <= '0;
      color_R16U     <= '0;
      box_r          <= '0;
      step_r         <= '0;
    end else if (accept) begin
      tri_R16S       <= tri_R15S;
      color_R16U     <= color_R15U;
      box_r          <= box_R15S;
      step_r         <= step_in;
      sample_R16S    <= box_R15S[0];
      validSamp_R16H <= 1'b1;
      // A single-point box needs no walk and therefore never stalls upstream.
      state          <= (box_R15S[0] == box_R15S[1]) ? WAIT_STATE : TEST_STATE;
    end else if (state == TEST_STATE) begin
      if (!last) begin
        if (sample_R16S[0] == box_r[1][0]) begin
          sample_R16S[0] <= box_r[0][0];
          sample_R16S[1] <= sample_R16S[1] + step_r;
        end else begin
          sample_R16S[0] <= sample_R16S[0] + step_r;
        end
      end else begin
        validSamp_R16H <= 1'b0;
        state          <= WAIT_STATE;
      end
    end else begin
      validSamp_R16H <= 1'b0;
    end
  end

endmodule
